// File: rtl/cur_blk_fetch_pkg.sv
// Shared types and helpers for the current-block fetch controller.
package cur_blk_fetch_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    DONE  = 2'd2
  } state_t;

  // Geometry of the default 1080p / 16x16 configuration
  localparam int unsigned DEF_FRAME_W   = 1920;
  localparam int unsigned DEF_FRAME_H   = 1080;
  localparam int unsigned DEF_BLK_SIZE  = 16;
  localparam int unsigned WORDS_PER_ROW = DEF_BLK_SIZE / 4;
  localparam int unsigned MB_COLS       = DEF_FRAME_W / DEF_BLK_SIZE;
  localparam int unsigned MB_ROWS       = DEF_FRAME_H / DEF_BLK_SIZE;

  // Byte address of the top-left pixel of macroblock (mb_x, mb_y); caller truncates to ADDR_W
  function automatic logic [63:0] blk_base(input logic [63:0] frame_base,
                                           input logic [7:0]  mb_x,
                                           input logic [7:0]  mb_y,
                                           input int unsigned frame_w,
                                           input int unsigned blk_size);
    return frame_base
         + 64'(mb_y) * 64'(blk_size) * 64'(frame_w)
         + 64'(mb_x) * 64'(blk_size);
  endfunction

endpackage

// File: rtl/cur_blk_fetch_addr_gen.sv
// Row/column counters and incremental row-base accumulator for one macroblock.
module cur_blk_addr_gen #(
  parameter int unsigned FRAME_W  = 1920,
  parameter int unsigned BLK_SIZE = 16,
  parameter int unsigned ADDR_W   = 32
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          load,
  input  logic [ADDR_W-1:0]             base,
  input  logic                          advance,
  output logic [ADDR_W-1:0]             addr,
  output logic [$clog2(BLK_SIZE)-1:0]   row,
  output logic [$clog2(BLK_SIZE/4)-1:0] col,
  output logic                          last_word
);

  localparam int unsigned WPR = BLK_SIZE / 4;
  localparam int unsigned RW  = $clog2(BLK_SIZE);
  localparam int unsigned CW  = $clog2(WPR);

  logic [ADDR_W-1:0] row_base;
  logic              col_last;

  assign col_last  = (col == CW'(WPR - 1));
  assign last_word = col_last && (row == RW'(BLK_SIZE - 1));

  // Address is kept registered and stepped by adds only: +4 along a row, +FRAME_W per row
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      row_base <= '0;
      addr     <= '0;
      row      <= '0;
      col      <= '0;
    end else if (load) begin
      row_base <= base;
      addr     <= base;
      row      <= '0;
      col      <= '0;
    end else if (advance) begin
      if (col_last) begin
        col      <= '0;
        row      <= row + RW'(1);
        row_base <= row_base + ADDR_W'(FRAME_W);
        addr     <= row_base + ADDR_W'(FRAME_W);
      end else begin
        col      <= col + CW'(1);
        addr     <= addr + ADDR_W'(4);
      end
    end
  end

endmodule

// File: rtl/cur_blk_fetch.sv
// Current-frame macroblock fetch controller: walks one BLK_SIZE x BLK_SIZE block
// word by word and streams it over valid/ready.
// Optional feature macro: CUR_BLK_FETCH_SUM_EN adds the blk_sum pixel-sum output.
module cur_blk_fetch
  import cur_blk_fetch_pkg::*;
#(
  parameter int unsigned FRAME_W  = 1920,
  parameter int unsigned FRAME_H  = 1080,
  parameter int unsigned BLK_SIZE = 16,
  parameter int unsigned ADDR_W   = 32
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          start,
  input  logic [ADDR_W-1:0]             frame_base,
  input  logic [7:0]                    mb_x,
  input  logic [7:0]                    mb_y,
  output logic                          mem_en,
  output logic [ADDR_W-1:0]             mem_addr,
  input  logic [31:0]                   mem_data,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [31:0]                   out_data,
  output logic [$clog2(BLK_SIZE)-1:0]   out_row,
  output logic [$clog2(BLK_SIZE/4)-1:0] out_col,
  output logic                          busy,
  output logic                          done,
  output logic                          err
`ifdef CUR_BLK_FETCH_SUM_EN
  ,
  output logic [$clog2(BLK_SIZE*BLK_SIZE*255+1)-1:0] blk_sum
`endif
);

  localparam int unsigned BLK_COLS = FRAME_W / BLK_SIZE;
  localparam int unsigned BLK_ROWS = FRAME_H / BLK_SIZE;

  state_t            state, state_nxt;
  logic              in_range;
  logic              load, advance, err_nxt;
  logic              last_word;
  logic [ADDR_W-1:0] base_load;

  assign in_range  = (32'(mb_x) < BLK_COLS) && (32'(mb_y) < BLK_ROWS);
  assign base_load = ADDR_W'(blk_base(64'(frame_base), mb_x, mb_y, FRAME_W, BLK_SIZE));

  cur_blk_addr_gen #(
    .FRAME_W  (FRAME_W),
    .BLK_SIZE (BLK_SIZE),
    .ADDR_W   (ADDR_W)
  ) u_addr_gen (
    .clk       (clk),
    .rst       (rst),
    .load      (load),
    .base      (base_load),
    .advance   (advance),
    .addr      (mem_addr),
    .row       (out_row),
    .col       (out_col),
    .last_word (last_word)
  );

  // State register and registered reject pulse
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      err   <= 1'b0;
    end else begin
      state <= state_nxt;
      err   <= err_nxt;
    end
  end

  // Next-state decode, handshake and per-state outputs
  always_comb begin
    state_nxt = state;
    mem_en    = 1'b0;
    out_valid = 1'b0;
    busy      = 1'b0;
    done      = 1'b0;
    load      = 1'b0;
    advance   = 1'b0;
    err_nxt   = 1'b0;
    out_data  = '0;
    unique case (state)
      IDLE: begin
        if (start) begin
          if (in_range) begin
            load      = 1'b1;
            state_nxt = FETCH;
          end else begin
            err_nxt = 1'b1;
          end
        end
      end
      FETCH: begin
        mem_en    = 1'b1;
        busy      = 1'b1;
        out_valid = 1'b1;
        out_data  = mem_data;
        if (out_ready) begin
          advance = 1'b1;
          if (last_word) state_nxt = DONE;
        end
      end
      DONE: begin
        done      = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

`ifdef CUR_BLK_FETCH_SUM_EN
  localparam int unsigned SUM_W = $clog2(BLK_SIZE*BLK_SIZE*255+1);

  logic [SUM_W-1:0] word_sum;

  assign word_sum = SUM_W'(mem_data[7:0])   + SUM_W'(mem_data[15:8])
                  + SUM_W'(mem_data[23:16]) + SUM_W'(mem_data[31:24]);

  // Pixel-sum accumulator: cleared on accepted start, summed per handshake, held otherwise
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      blk_sum <= '0;
    end else if (load) begin
      blk_sum <= '0;
    end else if (advance) begin
      blk_sum <= blk_sum + word_sum;
    end
  end
`endif

endmodule

// File: tb/tb_cur_blk_fetch.sv
// Scoreboard bench for cur_blk_fetch (default 1920x1080, 16x16 blocks).
module tb_cur_blk_fetch;

  localparam int unsigned FW = 1920;

  logic        clk, rst, start;
  logic [31:0] frame_base;
  logic [7:0]  mb_x, mb_y;
  logic        mem_en;
  logic [31:0] mem_addr, mem_data;
  logic        out_valid, out_ready;
  logic [31:0] out_data;
  logic [3:0]  out_row;
  logic [1:0]  out_col;
  logic        busy, done, err;
`ifdef CUR_BLK_FETCH_SUM_EN
  logic [15:0] blk_sum;
`endif

  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] data;
    logic [3:0]  row;
    logic [1:0]  col;
  } exp_t;

  exp_t q[$];
  int   compared   = 0;
  int   mismatched = 0;
  int   hs         = 0;
  int   dones      = 0;
  int   pat        = 0;
  logic rdy_rand   = 1'b0;

  // Memory model: pattern 0 -> byte[i] = i mod 256, 1 -> all 0x01, 2 -> all 0xFF
  function automatic logic [31:0] mem_word(input logic [31:0] a, input int p);
    if (p == 1) return 32'h0101_0101;
    if (p == 2) return 32'hFFFF_FFFF;
    return {8'(a + 32'd3), 8'(a + 32'd2), 8'(a + 32'd1), 8'(a)};
  endfunction

  assign mem_data = mem_word(mem_addr, pat);

  cur_blk_fetch #(
    .FRAME_W  (1920),
    .FRAME_H  (1080),
    .BLK_SIZE (16),
    .ADDR_W   (32)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .frame_base (frame_base),
    .mb_x       (mb_x),
    .mb_y       (mb_y),
    .mem_en     (mem_en),
    .mem_addr   (mem_addr),
    .mem_data   (mem_data),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_data   (out_data),
    .out_row    (out_row),
    .out_col    (out_col),
    .busy       (busy),
    .done       (done),
    .err        (err)
`ifdef CUR_BLK_FETCH_SUM_EN
    ,
    .blk_sum    (blk_sum)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
    #2;
  endtask

  task automatic push_block(input logic [31:0] base);
    for (int r = 0; r < 16; r++) begin
      for (int c = 0; c < 4; c++) begin
        exp_t e;
        e.addr = base + 32'(r) * FW + 32'(c) * 4;
        e.data = mem_word(e.addr, pat);
        e.row  = 4'(r);
        e.col  = 2'(c);
        q.push_back(e);
      end
    end
  endtask

  // Ready driver: changes just after the rising edge so it is stable at the sampling edge
  initial begin
    out_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      out_ready = rdy_rand ? ($urandom_range(0, 1) != 0) : 1'b1;
    end
  end

  // Monitor: pops the scoreboard on every handshake and checks stall stability
  logic        prev_stall = 1'b0;
  logic [31:0] prev_addr  = '0;
  logic [31:0] prev_data  = '0;
  always @(negedge clk) begin
    if (rst) begin
      prev_stall = 1'b0;
    end else begin
      if (prev_stall && out_valid) begin
        check("stall_addr", 64'(mem_addr), 64'(prev_addr));
        check("stall_data", 64'(out_data), 64'(prev_data));
      end
      if (out_valid && out_ready) begin
        if (q.size() == 0) begin
          compared++;
          mismatched++;
          $display("FAIL unexpected_word: addr 0x%0h with empty scoreboard", mem_addr);
        end else begin
          exp_t e;
          e = q.pop_front();
          check("word_addr", 64'(mem_addr), 64'(e.addr));
          check("word_data", 64'(out_data), 64'(e.data));
          check("word_rowcol", 64'({out_row, out_col}), 64'({e.row, e.col}));
        end
        hs++;
      end
      if (done) dones++;
      prev_stall = out_valid && !out_ready;
      prev_addr  = mem_addr;
      prev_data  = out_data;
    end
  end

  // Issue one start, optionally pulse a stray start mid-fetch, wait for done (cycle index returned)
  task automatic run_block(input logic [31:0] fb, input logic [7:0] x, input logic [7:0] y,
                           input logic [31:0] exp_base, input int stray_at, output int done_cyc);
    int h0;
    int n;
    h0 = hs;
    push_block(exp_base);
    frame_base = fb;
    mb_x       = x;
    mb_y       = y;
    start      = 1'b1;
    tick();
    start = 1'b0;
    n = 1;
    check("first_valid", 64'(out_valid), 64'd1);
    check("first_addr", 64'(mem_addr), 64'(exp_base));
    while (!done && n < 2000) begin
      if (n == stray_at) begin
        start      = 1'b1;
        frame_base = 32'h0BAD_0000;
        mb_x       = 8'd0;
        mb_y       = 8'd0;
      end else if (n == stray_at + 2) begin
        start = 1'b0;
      end
      tick();
      n++;
    end
    start = 1'b0;
    if (!done) begin
      compared++;
      mismatched++;
      $display("FAIL done_timeout: no done after %0d cycles", n);
    end
    done_cyc = n;
    check("hs_count", 64'(hs - h0), 64'd64);
    check("queue_drained", 64'(q.size()), 64'd0);
  endtask

  task automatic bad_start(input logic [7:0] x, input logic [7:0] y);
    mb_x  = x;
    mb_y  = y;
    start = 1'b1;
    tick();
    start = 1'b0;
    check("err_pulse", 64'(err), 64'd1);
    check("err_busy", 64'(busy), 64'd0);
    check("err_mem_en", 64'(mem_en), 64'd0);
    tick();
    check("err_clear", 64'(err), 64'd0);
    check("err_busy2", 64'({busy, mem_en, out_valid}), 64'd0);
  endtask

  initial begin
    int dc;
    int h0;
    int d0;
    int n;
    rst        = 1'b1;
    start      = 1'b0;
    frame_base = '0;
    mb_x       = '0;
    mb_y       = '0;
    repeat (3) tick();
    check("rst_mem_en", 64'(mem_en), 64'd0);
    check("rst_valid_busy_done_err", 64'({out_valid, busy, done, err}), 64'd0);
    check("rst_mem_addr", 64'(mem_addr), 64'd0);
    check("rst_rowcol_data", 64'({out_row, out_col, out_data}), 64'd0);
    rst = 1'b0;
    tick();

    // Block (1,2) at frame_base 0: 0xF010 .. 90268, done on cycle 65
    run_block(32'd0, 8'd1, 8'd2, 32'd61456, 0, dc);
    check("done_cycle", 64'(dc), 64'd65);
    tick();
    check("done_one_cycle", 64'({done, busy}), 64'd0);
    check("mem_addr_last_row_base", 64'(mem_addr), 64'd61456 + 64'd16 * FW);

    // Back-to-back start on cycle 66, highest legal block, random backpressure
    rdy_rand = 1'b1;
    run_block(32'h0010_0000, 8'd119, 8'd66, 32'h0010_0000 + 32'd2029424, 0, dc);
    rdy_rand = 1'b0;
    tick();
    check("idle_outputs", 64'({mem_en, out_valid, busy, out_data}), 64'd0);

    // Out-of-range requests
    bad_start(8'd120, 8'd0);
    bad_start(8'd0, 8'd67);
    bad_start(8'd255, 8'd255);

    // Stray start during FETCH is ignored
    run_block(32'h0000_4000, 8'd3, 8'd4, 32'h0000_4000 + 32'd4 * 16 * FW + 32'd48, 5, dc);
    tick();

    // Reset after 10 handshakes: immediate abort, no done
    h0 = hs;
    push_block(32'd7 * 16 * FW + 32'd5 * 16);
    frame_base = 32'd0;
    mb_x       = 8'd5;
    mb_y       = 8'd7;
    start      = 1'b1;
    tick();
    start = 1'b0;
    n = 0;
    while (hs - h0 < 10 && n < 200) begin
      tick();
      n++;
    end
    check("pre_reset_hs", 64'(hs - h0), 64'd10);
    rst = 1'b1;
    #1;
    check("abort_mem_en_valid_busy", 64'({mem_en, out_valid, busy, done}), 64'd0);
    check("abort_addr_data", 64'({mem_addr, out_data}), 64'd0);
    check("abort_rowcol", 64'({out_row, out_col}), 64'd0);
    q.delete();
    d0 = dones;
    tick();
    rst = 1'b0;
    repeat (5) tick();
    check("abort_no_done", 64'(dones - d0), 64'd0);
    check("abort_idle", 64'({busy, mem_en}), 64'd0);

`ifdef CUR_BLK_FETCH_SUM_EN
    pat = 1;
    run_block(32'd0, 8'd0, 8'd0, 32'd0, 0, dc);
    check("sum_ones", 64'(blk_sum), 64'd256);
    tick();
    check("sum_held", 64'(blk_sum), 64'd256);
    pat = 2;
    run_block(32'd0, 8'd2, 8'd1, 32'd16 * FW + 32'd32, 0, dc);
    check("sum_ff", 64'(blk_sum), 64'd65280);
    tick();
    pat = 0;
`endif

    check("final_queue_empty", 64'(q.size()), 64'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/cur_blk_fetch.md
Name: cur_blk_fetch

Overview:
- Fetch controller for the current-frame pixel memory in the motion-estimation path.
- On a start command it sequences word reads (4 pixels, byte-addressed, little-endian) over one BLK_SIZE x BLK_SIZE macroblock.
- Streams the words to the SAD/search engine over a valid/ready interface.
- Sole master of the memory's en/addr pins; the memory read is combinational (data follows addr/en the same cycle).

Parameters:
FRAME_W, 1920, frame width in pixels (bytes per row); multiple of BLK_SIZE
FRAME_H, 1080, frame height in pixels; MB_ROWS = floor(FRAME_H/BLK_SIZE)
BLK_SIZE, 16, macroblock edge in pixels; multiple of 4
ADDR_W, 32, memory byte-address width

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous active-high reset
start  in  1  one-cycle fetch request; sampled only in IDLE
frame_base  in  ADDR_W  byte address of pixel (0,0) of the frame; sampled with start
mb_x  in  8  macroblock column index; sampled with start
mb_y  in  8  macroblock row index; sampled with start
mem_en  out  1  memory enable
mem_addr  out  ADDR_W  memory byte address of the word
mem_data  in  32  memory read data; byte0 = leftmost pixel
out_valid  out  1  pixel word available
out_ready  in  1  consumer accepts the word
out_data  out  32  pixel word (mem_data passthrough)
out_row  out  $clog2(BLK_SIZE)  row of the word within the block
out_col  out  $clog2(BLK_SIZE/4)  word column within the row
busy  out  1  high in FETCH
done  out  1  one-cycle pulse after the last word is accepted
err  out  1  one-cycle pulse when start is rejected for out-of-range mb_x/mb_y

Behaviour:
- Reset values: all outputs 0, including mem_addr and the counters; state IDLE.
- Ports are 0 whenever not in FETCH: mem_en, out_valid, busy, out_data.
- FSM states: IDLE, FETCH, DONE.

IDLE:
- On start with mb_x < FRAME_W/BLK_SIZE and mb_y < MB_ROWS:
  - row_base <= frame_base + mb_y*BLK_SIZE*FRAME_W + mb_x*BLK_SIZE
  - row = 0, col = 0
  - go to FETCH
- On start with either index out of range: pulse err next cycle and stay in IDLE.

FETCH:
- Outputs: mem_en = 1, busy = 1, out_valid = 1.
- mem_addr = row_base + 4*col, registered from counters; no multiplier in the loop.
- out_data = mem_data, combinational; out_row = row, out_col = col.
- Handshake fires when out_valid && out_ready:
  - col increments.
  - At col = BLK_SIZE/4-1: col <= 0, row increments, row_base += FRAME_W.
- On the handshake with row = BLK_SIZE-1 and col = BLK_SIZE/4-1: go to DONE.
- out_ready low holds addr, row and col stable. Data must not change while stalled.

DONE:
- done = 1 for exactly one cycle, then IDLE.

Latency and throughput:
- start at cycle 0 gives the first out_valid at cycle 1.
- With out_ready held high: 64 words on cycles 1..64 (BLK=16), done on cycle 65.
- A new start is accepted on cycle 66.

Boundary conditions:
- start during FETCH/DONE is ignored; no queueing.
- Address arithmetic is ADDR_W-bit and wraps silently. The caller guarantees frame_base + frame size fits.
- rst mid-fetch aborts immediately to IDLE with outputs 0. No done is issued.

Optional Feature:
- Macro: CUR_BLK_FETCH_SUM_EN.
- Defined:
  - Adds output blk_sum, width $clog2(BLK_SIZE*BLK_SIZE*255+1) (16 for BLK=16).
  - It is the sum of all pixel bytes accepted during the fetch, accumulated on each handshake.
  - Cleared on the start that enters FETCH.
  - Valid (held) from the done cycle until the next accepted start; reset value 0.
- Undefined: port and accumulator absent; all other behaviour identical.

Decomposition:
- Package cur_blk_fetch_pkg holds:
  - State enum {IDLE, FETCH, DONE}.
  - Localparams WORDS_PER_ROW = BLK_SIZE/4, MB_COLS, MB_ROWS.
  - A function computing the block base address.
- One natural sub-module, cur_blk_addr_gen: row/col counters plus row_base accumulator, with advance/load inputs and last-word flag output. The FSM and handshake stay in the top.

Test Plan:
- Address start: frame_base=0, mb_x=1, mb_y=2, out_ready=1 -> first mem_addr 61456 (0xF010), last mem_addr 90268, 64 valid words, done at cycle 65.
- Data ordering: memory filled with byte[i] = i mod 256 -> each out_data equals the little-endian word at mem_addr; out_row/out_col sequence (0,0),(0,1)..(15,3).
- Backpressure: toggle out_ready pseudo-randomly -> addr/data stable while stalled, exactly 64 handshakes, no duplicates or skips.
- Range check: mb_x=120 (FRAME_W=1920) or mb_y=67 -> err pulse, busy stays 0, mem_en stays 0.
- Reset and ignored start: assert rst after 10 handshakes -> all outputs 0, no done. Separately, start during FETCH -> ignored, addresses unchanged.
- With CUR_BLK_FETCH_SUM_EN: all bytes 0x01 -> blk_sum=256; all bytes 0xFF -> blk_sum=65280 at done.
